// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, mid-bit sample point and the
// receiver state encoding. The transmitter pulls OVERSAMPLE and DATA_BITS
// from here so both ends of the link agree on the frame shape.
package uart_pkg;

   // Clock cycles per bit on the line.
   localparam int OVERSAMPLE = 16;

   // Data bits carried in each frame.
   localparam int DATA_BITS = 8;

   // Phase index inside the start bit where the line is re-checked. Every
   // later sample falls a whole bit period after this point, so all samples
   // land near the middle of their bit.
   localparam int MID_SAMPLE = 7;

   // Receiver state encoding.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rxState_t;

   // Width of a counter that must hold the values 0..n-1, never narrower
   // than one bit so a degenerate parameter still elaborates.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so an idle-high line never looks like a start bit coming out of reset.
module uart_sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the raw line through two flops to settle metastability.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver. The line is synchronized, then a five-state machine finds
// the start bit, samples each data bit at mid-bit, checks the stop bit and
// hands the byte to the consumer through a one-deep holding register with
// valid/acknowledge handshaking, overrun detection and framing-error pulses.
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rxPin,
   input  logic                 readAck,
   output logic [DATA_BITS-1:0] data,
   output logic                 dataValid,
   output logic                 framingError,
   output logic                 overrun
);

   import uart_pkg::*;

   localparam int CW = cntWidth(OVERSAMPLE);
   localparam int BW = cntWidth(DATA_BITS);

   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(MID_SAMPLE);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   logic                 rxS;
   rxState_t             state;
   rxState_t             stateNext;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cntNext;
   logic [CW-1:0]        cntInc;
   logic                 cntAtLast;
   logic [BW-1:0]        bitCnt;
   logic [BW-1:0]        bitCntNext;
   logic [DATA_BITS-1:0] shiftReg;
   logic [DATA_BITS-1:0] shiftNext;
   logic                 byteDone;
   logic                 stopFail;

   uart_sync2 sync (
      .clock (clock),
      .reset (reset),
      .d     (rxPin),
      .q     (rxS)
   );

   // The phase counter wraps at OVERSAMPLE-1 so a non-power-of-two rate still
   // gives exactly one sample per bit period.
   assign cntAtLast = (cnt == CNT_LAST);
   assign cntInc    = cntAtLast ? '0 : cnt + CW'(1);

   // Frame state, phase counter, bit counter and shift register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         bitCnt   <= '0;
         shiftReg <= '0;
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         bitCnt   <= bitCntNext;
         shiftReg <= shiftNext;
      end
   end

   // Frame sequencing: the counter sits at 0 in the cycle the low line is
   // first seen, so START re-checks at mid-bit and entering DATA clears it,
   // making every later sample fall one full bit period apart.
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      bitCntNext = bitCnt;
      shiftNext  = shiftReg;
      byteDone   = 1'b0;
      stopFail   = 1'b0;

      unique case (state)
         IDLE: begin
            cntNext    = '0;
            bitCntNext = '0;
            if (!rxS) begin
               stateNext = START;
               cntNext   = CW'(1);
            end
         end

         START: begin
            cntNext = cntInc;
            if (cnt == CNT_MID) begin
               cntNext = '0;
               if (rxS) begin
                  stateNext = IDLE;
               end else begin
                  stateNext = DATA;
               end
            end
         end

         DATA: begin
            cntNext = cntInc;
            if (cntAtLast) begin
               shiftNext = {rxS, shiftReg[DATA_BITS-1:1]};
               if (bitCnt == BIT_LAST) begin
                  bitCntNext = '0;
                  stateNext  = STOP;
               end else begin
                  bitCntNext = bitCnt + BW'(1);
               end
            end
         end

         STOP: begin
            cntNext = cntInc;
            if (cntAtLast) begin
               cntNext = '0;
               if (rxS) begin
                  byteDone  = 1'b1;
                  stateNext = IDLE;
               end else begin
                  stopFail  = 1'b1;
                  stateNext = BREAK;
               end
            end
         end

         BREAK: begin
            cntNext = '0;
            if (rxS) begin
               stateNext = IDLE;
            end
         end

         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   // Consumer handshake: a finished byte is taken when the holder is empty or
   // is being emptied this very cycle; otherwise it is dropped and overrun
   // sticks until the next acknowledge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data         <= '0;
         dataValid    <= 1'b0;
         framingError <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         framingError <= stopFail;

         if (readAck) begin
            overrun <= 1'b0;
         end

         if (byteDone) begin
            if (!dataValid || readAck) begin
               data      <= shiftReg;
               dataValid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (readAck) begin
            dataValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: a table of whole frames followed by hand-written
// sequences for start glitch, latency, overrun, mid-frame reset and an
// acknowledge that coincides with byte completion.
module tb_uart_rx;

   logic       clock;
   logic       reset;
   logic       rxPin;
   logic       readAck;
   logic [7:0] data;
   logic       dataValid;
   logic       framingError;
   logic       overrun;

   int compareCount;
   int mismatchCount;
   int cycleCount;
   int startCycle;
   int riseCycle;
   int feCount;
   int feBefore;
   logic dvPrev;

   typedef struct {
      logic [7:0] payload;
      logic       stopBit;
      int         lowHold;
      logic [7:0] expData;
      logic       expValid;
      int         expFe;
   } vec_t;

   vec_t vectors[6];

   uart_rx #(
      .OVERSAMPLE (16),
      .DATA_BITS  (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .rxPin        (rxPin),
      .readAck      (readAck),
      .data         (data),
      .dataValid    (dataValid),
      .framingError (framingError),
      .overrun      (overrun)
   );

   // 100 MHz clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Free-running edge counter used to time latencies.
   always @(posedge clock) begin
      cycleCount <= cycleCount + 1;
   end

   // Count framing-error pulses and note the cycle dataValid rises.
   always @(negedge clock) begin
      if (framingError === 1'b1) feCount++;
      if (dataValid === 1'b1 && dvPrev !== 1'b1) riseCycle = cycleCount;
      dvPrev = dataValid;
   end

   // Give up if the run never reaches its summary.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: run did not finish, compared=%0d", compareCount);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compareCount++;
      if (actual !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one frame, 16 clocks per bit, starting at a falling clock edge.
   // A stop bit of 0 keeps the line low for lowHold more clocks. abortBit
   // pulses reset halfway through that data bit and abandons the frame.
   task automatic applyStimulus(input logic [7:0] payload, input logic stopBit,
                                input int lowHold, input int abortBit);
      @(negedge clock);
      startCycle = cycleCount;
      rxPin = 1'b0;
      repeat (16) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxPin = payload[i];
         if (i == abortBit) begin
            repeat (8) @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            rxPin = 1'b1;
            repeat (24) @(negedge clock);
            return;
         end
         repeat (16) @(negedge clock);
      end
      rxPin = stopBit;
      repeat (16) @(negedge clock);
      if (!stopBit) begin
         repeat (lowHold) @(negedge clock);
         rxPin = 1'b1;
         repeat (16) @(negedge clock);
      end
   endtask

   task automatic pulseAck();
      @(negedge clock);
      readAck = 1'b1;
      @(negedge clock);
      readAck = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      cycleCount    = 0;
      feCount       = 0;
      reset   = 1'b1;
      rxPin   = 1'b1;
      readAck = 1'b0;

      vectors[0] = '{8'hA3, 1'b1, 0,  8'hA3, 1'b1, 0};
      vectors[1] = '{8'h3C, 1'b0, 40, 8'hA3, 1'b0, 1};
      vectors[2] = '{8'h81, 1'b1, 0,  8'h81, 1'b1, 0};
      vectors[3] = '{8'h00, 1'b1, 0,  8'h00, 1'b1, 0};
      vectors[4] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b1, 0};
      vectors[5] = '{8'h5A, 1'b1, 0,  8'h5A, 1'b1, 0};

      $display("[TB] uart_rx test start");

      // Outputs while reset is held.
      repeat (3) @(negedge clock);
      checkOutput("resetData", data, 8'h00);
      checkOutput("resetValid", dataValid, 1'b0);
      checkOutput("resetFrameErr", framingError, 1'b0);
      checkOutput("resetOverrun", overrun, 1'b0);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      // Four-clock low glitch must not start a frame.
      feBefore = feCount;
      rxPin = 1'b0;
      repeat (4) @(negedge clock);
      rxPin = 1'b1;
      repeat (24) @(negedge clock);
      checkOutput("glitchValid", dataValid, 1'b0);
      checkOutput("glitchFrameErr", feCount - feBefore, 0);

      // Table of whole frames, each acknowledged when a byte is expected.
      for (int v = 0; v < 6; v++) begin
         feBefore = feCount;
         applyStimulus(vectors[v].payload, vectors[v].stopBit, vectors[v].lowHold, -1);
         repeat (4) @(negedge clock);
         checkOutput($sformatf("vec%0dData", v), data, vectors[v].expData);
         checkOutput($sformatf("vec%0dValid", v), dataValid, vectors[v].expValid);
         checkOutput($sformatf("vec%0dFrameErr", v), feCount - feBefore, vectors[v].expFe);
         checkOutput($sformatf("vec%0dOverrun", v), overrun, 1'b0);
         if (vectors[v].expValid) pulseAck();
         checkOutput($sformatf("vec%0dAckValid", v), dataValid, 1'b0);
      end

      // Latency: the line falls at startCycle, rxS two edges later (t0), and
      // dataValid is visible from t0+152, i.e. 154 edges after the drive.
      applyStimulus(8'h55, 1'b1, 0, -1);
      repeat (4) @(negedge clock);
      checkOutput("latencyData", data, 8'h55);
      checkOutput("latencyCycles", riseCycle - startCycle, 154);
      pulseAck();

      // Two back-to-back frames with no acknowledge: the second is dropped.
      applyStimulus(8'h11, 1'b1, 0, -1);
      applyStimulus(8'h22, 1'b1, 0, -1);
      repeat (4) @(negedge clock);
      checkOutput("overrunData", data, 8'h11);
      checkOutput("overrunValid", dataValid, 1'b1);
      checkOutput("overrunFlag", overrun, 1'b1);
      pulseAck();
      checkOutput("overrunAckValid", dataValid, 1'b0);
      checkOutput("overrunAckFlag", overrun, 1'b0);

      // Acknowledge with nothing held changes nothing.
      pulseAck();
      checkOutput("idleAckValid", dataValid, 1'b0);
      checkOutput("idleAckData", data, 8'h11);

      // Acknowledge landing on the very edge the second byte completes.
      applyStimulus(8'h44, 1'b1, 0, -1);
      repeat (4) @(negedge clock);
      checkOutput("coincFirstData", data, 8'h44);
      fork
         applyStimulus(8'h99, 1'b1, 0, -1);
         begin
            @(negedge clock);
            repeat (153) @(posedge clock);
            @(negedge clock);
            readAck = 1'b1;
            @(negedge clock);
            readAck = 1'b0;
         end
      join
      repeat (4) @(negedge clock);
      checkOutput("coincData", data, 8'h99);
      checkOutput("coincValid", dataValid, 1'b1);
      checkOutput("coincOverrun", overrun, 1'b0);
      pulseAck();

      // Reset in the middle of data bit 4 abandons the frame silently.
      feBefore = feCount;
      applyStimulus(8'hF0, 1'b1, 0, 4);
      checkOutput("abortValid", dataValid, 1'b0);
      checkOutput("abortData", data, 8'h00);
      checkOutput("abortFrameErr", feCount - feBefore, 0);
      applyStimulus(8'h0F, 1'b1, 0, -1);
      repeat (4) @(negedge clock);
      checkOutput("afterAbortData", data, 8'h0F);
      checkOutput("afterAbortValid", dataValid, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
